// File: rtl/mem_cache_pkg.sv
// Shared types and helpers for the MEM-stage direct-mapped cache.
// Holds the controller state encoding and the SRAM beat-count derivation.
package mem_cache_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Number of SRAM beats needed to move one 32-bit word.
   function automatic int unsigned calc_nbeats(input int unsigned sram_w);
      return 32 / sram_w;
   endfunction

endpackage

// File: rtl/mem_cache_beat_ctr.sv
// Wait-cycle and beat sequencing for SRAM transfers.
// Counts run only while en is high and restart from zero whenever en drops.
module mem_cache_beat_ctr #(
   parameter int NBEATS      = 2,
   parameter int WAIT_CYCLES = 5,
   parameter int BEAT_W      = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [BEAT_W-1:0] beat,
   output logic              beat_last,
   output logic              xfer_done
);

   localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   logic [WAIT_W-1:0] wait_cnt;
   logic [BEAT_W-1:0] beat_q;

   assign beat      = beat_q;
   assign beat_last = en && (wait_cnt == WAIT_W'(WAIT_CYCLES - 1));
   assign xfer_done = beat_last && (beat_q == BEAT_W'(NBEATS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt <= '0;
         beat_q   <= '0;
      end else if (!en) begin
         wait_cnt <= '0;
         beat_q   <= '0;
      end else if (beat_last) begin
         wait_cnt <= '0;
         beat_q   <= xfer_done ? '0 : beat_q + 1'b1;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage_cache.sv
// Direct-mapped, one-word-per-line cache in front of a narrow multi-cycle SRAM.
// Reads allocate on miss; writes go straight through and never allocate.
module mem_stage_cache
   import mem_cache_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int SETS        = 64,
   parameter int SRAM_W      = 16,
   parameter int SRAM_AW     = 18,
   parameter int WAIT_CYCLES = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  addr,
   input  logic [31:0]        wdata,
   input  logic               flush,
   output logic [31:0]        rdata,
   output logic               ready,
   output logic               sram_en,
   output logic               sram_we_n,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_W-1:0]  sram_wdata,
   input  logic [SRAM_W-1:0]  sram_rdata,
   output logic [15:0]        hit_cnt,
   output logic [15:0]        miss_cnt
);

   localparam int NBEATS = calc_nbeats(SRAM_W);
   localparam int SET_W  = $clog2(SETS);
   localparam int WORD_W = ADDR_W - 2;
   localparam int TAG_W  = WORD_W - SET_W;
   localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int FULL_W = ADDR_W + SRAM_AW;

   state_e state, state_nxt;

   logic [WORD_W-1:0]  word_in, word_q;
   logic [SET_W-1:0]   set_in, set_q;
   logic [TAG_W-1:0]   tag_in, tag_q;
   logic [31:0]        wdata_q, fill_buf, fill_word;
   logic [SETS-1:0]    valid;
   logic [TAG_W-1:0]   tag_arr [SETS];
   logic [31:0]        data_arr [SETS];

   logic               in_idle, hit_in, do_flush, accept_rd, accept_wr, xfer_active;
   logic [BEAT_W-1:0]  beat;
   logic               beat_last, xfer_done;
   logic [FULL_W-1:0]  beat_addr_full;
   logic [SRAM_AW-1:0] addr_cur, addr_hold;
   logic [SRAM_W-1:0]  wslice, wdata_hold;

   assign word_in = addr[ADDR_W-1:2];
   assign set_in  = word_in[SET_W-1:0];
   assign tag_in  = word_in[WORD_W-1:SET_W];
   assign set_q   = word_q[SET_W-1:0];
   assign tag_q   = word_q[WORD_W-1:SET_W];

   // Flush outranks any request; a write outranks a simultaneous read.
   assign in_idle     = (state == IDLE);
   assign hit_in      = valid[set_in] && (tag_arr[set_in] == tag_in);
   assign do_flush    = in_idle && flush;
   assign accept_wr   = in_idle && !flush && wr_en;
   assign accept_rd   = in_idle && !flush && rd_en && !wr_en;
   assign xfer_active = (state == FILL) || (state == WRITE);

   mem_cache_beat_ctr #(
      .NBEATS      (NBEATS),
      .WAIT_CYCLES (WAIT_CYCLES),
      .BEAT_W      (BEAT_W)
   ) u_beat_ctr (
      .clk       (clk),
      .rst       (rst),
      .en        (xfer_active),
      .beat      (beat),
      .beat_last (beat_last),
      .xfer_done (xfer_done)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (accept_wr) begin
               state_nxt = WRITE;
            end else if (accept_rd && !hit_in) begin
               state_nxt = FILL;
            end
         end
         FILL, WRITE: begin
            if (xfer_done) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready = 1'b0;
      if (in_idle) begin
         ready = !flush && (accept_rd ? hit_in : !wr_en);
      end else if (state == DONE) begin
         ready = 1'b1;
      end
   end

   always_comb begin
      rdata = '0;
      if (accept_rd && hit_in) begin
         rdata = data_arr[set_in];
      end else if (state == DONE) begin
         rdata = fill_buf;
      end
   end

   // Beat b carries bits [b*SRAM_W +: SRAM_W], least-significant beat first.
   always_comb begin
      fill_word = fill_buf;
      wslice    = '0;
      for (int b = 0; b < NBEATS; b++) begin
         if (beat == BEAT_W'(b)) begin
            fill_word[b*SRAM_W +: SRAM_W] = sram_rdata;
            wslice                        = wdata_q[b*SRAM_W +: SRAM_W];
         end
      end
   end

   assign beat_addr_full = FULL_W'(word_q) * FULL_W'(NBEATS) + FULL_W'(beat);
   assign addr_cur       = beat_addr_full[SRAM_AW-1:0];

   // Address and write data are live during a transfer and hold otherwise.
   assign sram_en    = xfer_active;
   assign sram_we_n  = (state != WRITE);
   assign sram_addr  = xfer_active ? addr_cur : addr_hold;
   assign sram_wdata = (state == WRITE) ? wslice : wdata_hold;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         valid      <= '0;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
         word_q     <= '0;
         wdata_q    <= '0;
         fill_buf   <= '0;
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else begin
         state <= state_nxt;
         if (accept_rd || accept_wr) begin
            word_q  <= word_in;
            wdata_q <= wdata;
         end
         if (accept_rd) begin
            if (hit_in) begin
               if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
               if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
         end
         if (do_flush) begin
            valid <= '0;
         end else if ((state == FILL) && xfer_done) begin
            valid[set_q] <= 1'b1;
         end
         if ((state == FILL) && beat_last) fill_buf <= fill_word;
         if (xfer_active) addr_hold <= addr_cur;
         if (state == WRITE) wdata_hold <= wslice;
      end
   end

   // Tag and data storage carry no reset; valid bits gate every use.
   always_ff @(posedge clk) begin
      if (accept_wr && hit_in) begin
         data_arr[set_in] <= wdata;
      end
      if ((state == FILL) && xfer_done) begin
         data_arr[set_q] <= fill_word;
         tag_arr[set_q]  <= tag_q;
      end
   end

endmodule

// File: tb/tb_mem_stage_cache.sv
// Scoreboard bench for mem_stage_cache with default parameters and a
// behavioural 16-bit SRAM whose contents the bench owns.
module tb_mem_stage_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd_en, wr_en, flush;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        sram_en, sram_we_n;
   logic [17:0] sram_addr;
   logic [15:0] sram_wdata, sram_rdata;
   logic [15:0] hit_cnt, miss_cnt;

   logic [15:0] sram_mem [256];
   logic [31:0] exp_q [$];
   logic [17:0] seen_addr [4];
   logic [15:0] seen_data [4];
   int          nseen;
   int          n_checks = 0;
   int          n_pass   = 0;
   int          hit_m    = 0;
   int          miss_m   = 0;

   always #5 clk = ~clk;

   assign sram_rdata = sram_mem[sram_addr[7:0]];

   mem_stage_cache dut (
      .clk        (clk),
      .rst        (rst),
      .rd_en      (rd_en),
      .wr_en      (wr_en),
      .addr       (addr),
      .wdata      (wdata),
      .flush      (flush),
      .rdata      (rdata),
      .ready      (ready),
      .sram_en    (sram_en),
      .sram_we_n  (sram_we_n),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Walk the busy phase at negedges, logging each distinct SRAM beat.
   task automatic wait_done(output int lat, output int en_cyc, output int we_cyc);
      lat = 0; en_cyc = 0; we_cyc = 0; nseen = 0;
      @(negedge clk);
      while (!ready && lat < 100) begin
         if (sram_en) begin
            en_cyc++;
            if (!sram_we_n) we_cyc++;
            if (nseen == 0 || sram_addr != seen_addr[(nseen - 1) % 4]) begin
               if (nseen < 4) begin
                  seen_addr[nseen] = sram_addr;
                  seen_data[nseen] = sram_wdata;
               end
               nseen++;
            end
         end
         lat++;
         @(negedge clk);
      end
      chk("busy_ends_ready", 32'(ready), 1);
   endtask

   task automatic check_cnts(input string tag);
      chk({tag, "_hit_cnt"}, 32'(hit_cnt), hit_m);
      chk({tag, "_miss_cnt"}, 32'(miss_cnt), miss_m);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [31:0] exp_word,
                          input bit exp_hit, input logic [17:0] b0);
      int lat, en_cyc, we_cyc;
      exp_q.push_back(exp_word);
      @(posedge clk); #1;
      rd_en = 1'b1; addr = a;
      @(negedge clk);
      if (exp_hit) begin
         chk("hit_ready", 32'(ready), 1);
         chk("hit_sram_en", 32'(sram_en), 0);
         chk("hit_rdata", rdata, exp_q.pop_front());
         @(posedge clk); #1;
         rd_en = 1'b0;
         hit_m++;
      end else begin
         chk("miss_accept_ready", 32'(ready), 0);
         @(posedge clk); #1;
         rd_en = 1'b0;
         wait_done(lat, en_cyc, we_cyc);
         chk("fill_latency", lat, 10);
         chk("fill_en_cycles", en_cyc, 10);
         chk("fill_we_cycles", we_cyc, 0);
         chk("fill_beats", nseen, 2);
         chk("fill_beat0_addr", 32'(seen_addr[0]), 32'(b0));
         chk("fill_beat1_addr", 32'(seen_addr[1]), 32'(b0) + 1);
         chk("fill_rdata", rdata, exp_q.pop_front());
         miss_m++;
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input bit also_rd, input logic [17:0] b0);
      int lat, en_cyc, we_cyc;
      @(posedge clk); #1;
      wr_en = 1'b1; rd_en = also_rd; addr = a; wdata = d;
      @(negedge clk);
      chk("wr_accept_ready", 32'(ready), 0);
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0;
      wait_done(lat, en_cyc, we_cyc);
      chk("wr_latency", lat, 10);
      chk("wr_we_cycles", we_cyc, 10);
      chk("wr_beats", nseen, 2);
      chk("wr_beat0_addr", 32'(seen_addr[0]), 32'(b0));
      chk("wr_beat0_data", 32'(seen_data[0]), 32'(d[15:0]));
      chk("wr_beat1_addr", 32'(seen_addr[1]), 32'(b0) + 1);
      chk("wr_beat1_data", 32'(seen_data[1]), 32'(d[31:16]));
      sram_mem[b0[7:0]]         = d[15:0];
      sram_mem[b0[7:0] + 8'd1]  = d[31:16];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0;
      addr = '0; wdata = '0;
      for (int i = 0; i < 256; i++) sram_mem[i] = 16'h0;
      sram_mem[8'h20] = 16'h1234;
      sram_mem[8'h21] = 16'hABCD;
      sram_mem[8'hA0] = 16'h5555;
      sram_mem[8'hA1] = 16'h6666;
      #1;
      chk("rst_sram_en", 32'(sram_en), 0);
      chk("rst_sram_we_n", 32'(sram_we_n), 1);
      chk("rst_sram_addr", 32'(sram_addr), 0);
      chk("rst_rdata", rdata, 0);
      check_cnts("rst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(ready), 1);

      // Cold miss, then hit, then write-through hit and readback.
      do_read(32'h40, 32'hABCD1234, 1'b0, 18'h20);
      check_cnts("cold");
      do_read(32'h40, 32'hABCD1234, 1'b1, 18'h20);
      check_cnts("hit");
      do_write(32'h40, 32'hDEADBEEF, 1'b0, 18'h20);
      do_read(32'h40, 32'hDEADBEEF, 1'b1, 18'h20);
      check_cnts("wr_hit");

      // Same set, different tag: eviction both ways.
      do_read(32'h140, 32'h66665555, 1'b0, 18'hA0);
      do_read(32'h40, 32'hDEADBEEF, 1'b0, 18'h20);
      check_cnts("evict");

      // Asynchronous reset in the 4th cycle of a fill.
      @(posedge clk); #1;
      rd_en = 1'b1; addr = 32'h140;
      @(posedge clk); #1;
      rd_en = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("rst_mid_sram_en", 32'(sram_en), 0);
      chk("rst_mid_sram_we_n", 32'(sram_we_n), 1);
      chk("rst_mid_sram_addr", 32'(sram_addr), 0);
      hit_m = 0; miss_m = 0;
      check_cnts("rst_mid");
      @(posedge clk); #1 rst = 1'b1;
      do_read(32'h40, 32'hDEADBEEF, 1'b0, 18'h20);
      check_cnts("post_rst");

      // Write wins over a simultaneous read; counters untouched.
      do_write(32'h80, 32'h12345678, 1'b1, 18'h40);
      check_cnts("wr_rd_both");

      // Flush beats a same-cycle read that would otherwise hit.
      @(posedge clk); #1;
      flush = 1'b1; rd_en = 1'b1; addr = 32'h40;
      @(negedge clk);
      chk("flush_ready", 32'(ready), 0);
      @(posedge clk); #1;
      flush = 1'b0; rd_en = 1'b0;
      check_cnts("flush");
      do_read(32'h40, 32'hDEADBEEF, 1'b0, 18'h20);
      check_cnts("post_flush");
      do_read(32'h80, 32'h12345678, 1'b0, 18'h40);
      check_cnts("no_alloc");

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_cache.md
MEM_STAGE_CACHE -- requirements
Module: mem_stage_cache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: CPU byte-address width.
REQ-002 SHALL have parameter SETS, default 64: direct-mapped line count, one 32-bit word per line, power of two.
REQ-003 SHALL have parameter SRAM_W, default 16: SRAM data width, divides 32; NBEATS = 32/SRAM_W.
REQ-004 SHALL have parameter SRAM_AW, default 18: SRAM address width.
REQ-005 SHALL have parameter WAIT_CYCLES, default 5: cycles per SRAM beat, at least 1.
REQ-006 Port: clk  input  1  sole clock, rising edge.
REQ-007 Port: rst  input  1  asynchronous, active-low reset.
REQ-008 Port: rd_en  input  1  read request.
REQ-009 Port: wr_en  input  1  write request.
REQ-010 Port: addr  input  ADDR_W  byte address; bits [1:0] are ignored.
REQ-011 Port: wdata  input  32  write data.
REQ-012 Port: flush  input  1  invalidate all lines.
REQ-013 Port: rdata  output  32  read data, valid when ready=1 on a read.
REQ-014 Port: ready  output  1  high means the request completes this cycle; the pipeline stalls on ~ready.
REQ-015 Port: sram_en  output  1  SRAM access strobe.
REQ-016 Port: sram_we_n  output  1  SRAM write enable, active-low.
REQ-017 Port: sram_addr  output  SRAM_AW  SRAM beat address.
REQ-018 Port: sram_wdata  output  SRAM_W  SRAM write data.
REQ-019 Port: sram_rdata  input  SRAM_W  SRAM read data.
REQ-020 Port: hit_cnt, miss_cnt  output  16 each  read statistics.

Function
REQ-021 Address decode SHALL be: word = addr[ADDR_W-1:2]; set = word[log2(SETS)-1:0]; tag = the remaining upper bits of word.
REQ-022 FSM states SHALL be IDLE, FILL, WRITE, DONE; requests SHALL be sampled only in IDLE, and addr/wdata SHALL be latched on acceptance.
REQ-023 In IDLE with no request, ready SHALL be 1.
REQ-024 A read hit in IDLE SHALL give ready=1 and rdata=line in the same cycle, with no SRAM activity and no state change.
REQ-025 A read miss SHALL move to FILL with ready=0.
REQ-026 Each FILL beat b (0..NBEATS-1, least-significant part first) SHALL:
- drive sram_en=1 and sram_addr = (word*NBEATS + b) truncated to SRAM_AW, held for WAIT_CYCLES cycles;
- capture sram_rdata on the last cycle of the beat.
REQ-027 After the final FILL beat, the line's data, tag and valid bit SHALL be written, and the FSM SHALL go to DONE.
REQ-028 Any write (wr_en) SHALL be write-through with no-allocate:
- move to WRITE with ready=0;
- each beat drives sram_en=1 and sram_we_n=0 for WAIT_CYCLES cycles, with the matching wdata slice;
- on a hit the line data updates at acceptance; on a miss the cache is untouched;
- the FSM then goes to DONE.
REQ-029 DONE SHALL last one cycle with ready=1 and rdata = the filled word (read) or don't-care (write), then go to IDLE.
REQ-030 Miss or write latency SHALL be NBEATS*WAIT_CYCLES cycles with ready=0, plus one DONE cycle.
REQ-031 If rd_en and wr_en are both high, the write SHALL win and the read SHALL be dropped.
REQ-032 flush in IDLE SHALL clear all valid bits next edge and take priority over a same-cycle request; ready=0 for that cycle, and the request is re-sampled after.
REQ-033 flush outside IDLE SHALL be ignored.
REQ-034 hit_cnt and miss_cnt SHALL increment on read acceptance only, and SHALL saturate at 16'hFFFF.
REQ-035 Outside FILL and WRITE: sram_en=0, sram_we_n=1, and sram_addr and sram_wdata hold their last values.

Reset
REQ-036 When rst is low, all of the following SHALL take effect asynchronously, aborting any beat in progress:
- state=IDLE;
- all valid bits cleared;
- hit_cnt=miss_cnt=0;
- sram_en=0, sram_we_n=1;
- sram_addr=0, sram_wdata=0;
- rdata=0.
REQ-037 Tag and data arrays SHALL need no reset.

Structure
REQ-038 Package mem_cache_pkg SHALL hold the FSM state enum and the NBEATS derivation.
REQ-039 Sub-module mem_cache_beat_ctr SHALL hold the wait-cycle and beat counters, with outputs beat_last and xfer_done.

Verification (defaults)
REQ-040 Read 0x40 cold, SRAM returning 0x1234 then 0xABCD -> sram_addr 0x20 then 0x21, ready=0 for 10 cycles, then DONE with rdata=0xABCD1234 and miss_cnt=1.
REQ-041 Read 0x40 again -> ready=1 the same cycle, rdata=0xABCD1234, sram_en stays 0, hit_cnt=1.
REQ-042 Write 0xDEADBEEF to 0x40 -> sram_we_n=0 for 10 cycles with 0xBEEF@0x20 then 0xDEAD@0x21; a following read of 0x40 hits with 0xDEADBEEF.
REQ-043 Read 0x140 (same set, new tag) -> miss evicts; the next read of 0x40 misses, and miss_cnt increments each time.
REQ-044 rst low during cycle 4 of a fill -> sram_en=0 immediately; after release, a read of 0x40 misses.
REQ-045 rd_en and wr_en both high to 0x80 -> only the write is performed and counters are unchanged; flush then a read of 0x40 -> miss.
